param_input_pio_edge_irq: RTL

//  Parametrised Avalon-MM input PIO, generalising the fixed 24-bit input PIO.
//  - 2-FF synchroniser on in_port; configurable per-bit edge capture; maskable level interrupt.
//  - Sits between asynchronous board inputs (switches, keys, sensor lines) and the HPS/Nios bus.

---
 rtl/param_input_pio_edge_irq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/param_input_pio_edge_irq.sv
// -----------------------------------------------------------------------------
// param_input_pio_edge_irq
//
// Avalon-MM input PIO with a configurable width. The asynchronous in_port lines
// are brought into the clk domain by a two-flop synchroniser. A third flop keeps
// the previous synchronised value for edge detection. Per-bit sticky
// edge-capture flags are gated by a per-bit mask to form a level interrupt.
//
// Parameters
//   WIDTH       input port width, 1..32; readdata bits above WIDTH read 0
//   EDGE_TYPE   0 = rising, 1 = falling, 2 = any edge
//   BIT_CLEAR   1: an edgecapture write clears only the bits set in writedata
//               0: any edgecapture write clears every bit
//   RESET_VALUE reset value of the interrupt mask (low WIDTH bits are used)
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high reset
//   address    word address: 0 data (RO), 1 reserved, 2 irqmask (RW),
//              3 edgecapture (RO, write-to-clear)
//   chipselect Avalon chip select (qualifies writes only)
//   write_n    Avalon write strobe, active low
//   writedata  Avalon write data
//   readdata   registered read data, read latency 1, zero-extended
//   in_port    asynchronous external inputs
//   irq        level interrupt, |(edgecapture & irqmask)
// -----------------------------------------------------------------------------
module param_input_pio_edge_irq #(
   parameter int unsigned WIDTH       = 24,
   parameter int unsigned EDGE_TYPE   = 0,
   parameter bit          BIT_CLEAR   = 1'b1,
   parameter logic [31:0] RESET_VALUE = 32'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;
   logic [WIDTH-1:0] prev_reg;
   logic [WIDTH-1:0] irqmask_reg;
   logic [WIDTH-1:0] irqmask_next;
   logic [WIDTH-1:0] edgecapture_reg;
   logic [WIDTH-1:0] edgecapture_next;
   logic [31:0]      readdata_reg;
   logic [31:0]      readdata_next;
   logic [1:0]       arm_cnt_reg;
   logic [1:0]       arm_cnt_next;

   logic [WIDTH-1:0] rise_vec;
   logic [WIDTH-1:0] fall_vec;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] cap_clear;
   logic             armed;
   logic             wr_mask;
   logic             wr_capture;

   // Only the low WIDTH bits of writedata carry meaning; the rest are
   // deliberately dropped.
   logic [31:0]      wdata_unused;
   assign wdata_unused = writedata;

   assign wr_mask    = chipselect & ~write_n & (address == 2'd2);
   assign wr_capture = chipselect & ~write_n & (address == 2'd3);

   // The synchroniser and prev flops all come out of reset at 0. An input
   // already high at reset release therefore looks like a rising edge for one
   // cycle. Edges stay ignored until the counter saturates, so that false edge
   // never reaches edgecapture.
   assign armed        = (arm_cnt_reg == 2'd3);
   assign arm_cnt_next = armed ? arm_cnt_reg : arm_cnt_reg + 2'd1;

   assign rise_vec = sync2_reg & ~prev_reg;
   assign fall_vec = ~sync2_reg & prev_reg;
   assign edge_det = (EDGE_TYPE == 0) ? rise_vec :
                     (EDGE_TYPE == 1) ? fall_vec :
                                        (rise_vec | fall_vec);

   assign cap_clear = !wr_capture ? {WIDTH{1'b0}} :
                      BIT_CLEAR   ? writedata[WIDTH-1:0] :
                                    {WIDTH{1'b1}};

   assign irqmask_next = wr_mask ? writedata[WIDTH-1:0] : irqmask_reg;

   // If a new edge and a clear hit the same bit in the same cycle, the set
   // takes priority, so an edge is never lost.
   genvar gi;
   generate
      for (gi = 0; gi < int'(WIDTH); gi++) begin : g_capture
         assign edgecapture_next[gi] = (edge_det[gi] & armed) ? 1'b1 :
                                       cap_clear[gi]          ? 1'b0 :
                                                                edgecapture_reg[gi];
      end
   endgenerate

   // Read mux is unconditional and side-effect free. A read of edgecapture
   // in the clearing cycle samples the pre-clear register value.
   always_comb begin
      readdata_next = 32'd0;
      case (address)
         2'd0:    readdata_next[WIDTH-1:0] = sync2_reg;
         2'd2:    readdata_next[WIDTH-1:0] = irqmask_reg;
         2'd3:    readdata_next[WIDTH-1:0] = edgecapture_reg;
         default: readdata_next = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg       <= '0;
         sync2_reg       <= '0;
         prev_reg        <= '0;
         irqmask_reg     <= RESET_VALUE[WIDTH-1:0];
         edgecapture_reg <= '0;
         readdata_reg    <= 32'd0;
         arm_cnt_reg     <= 2'd0;
      end else begin
         sync1_reg       <= in_port;
         sync2_reg       <= sync1_reg;
         prev_reg        <= sync2_reg;
         irqmask_reg     <= irqmask_next;
         edgecapture_reg <= edgecapture_next;
         readdata_reg    <= readdata_next;
         arm_cnt_reg     <= arm_cnt_next;
      end
   end

   assign readdata = readdata_reg;

   // Built only from registers, so irq cannot glitch on bus or input activity.
   assign irq = |(edgecapture_reg & irqmask_reg);

endmodule
